// File: rtl/keccak_round_ctrl.sv
// Sequencer for an iterative Keccak-f[1600] core: absorb, permute and squeeze strobes.
// Latency: start -> state_clr next cycle, first in_ready 2 cycles after start; UNROLL rounds/clock.
// Backpressure: ABSORB waits on in_valid, SQUEEZE holds out_valid until out_ready; PERMUTE never stalls.
module keccak_round_ctrl #(
   parameter int NUM_ROUNDS = 24,
   parameter int UNROLL     = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [CNT_WIDTH-1:0] num_in_blocks,
   input  logic [CNT_WIDTH-1:0] num_out_blocks,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 absorb_en,
   output logic                 state_clr,
   output logic                 round_en,
   output logic [4:0]           round,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      INIT    = 3'd1,
      ABSORB  = 3'd2,
      PERMUTE = 3'd3,
      SQUEEZE = 3'd4,
      DONE    = 3'd5
   } state_t;

   // Round index step per clock and the base index of the final permutation cycle.
   localparam logic [4:0] STEP = 5'(UNROLL);
   localparam logic [4:0] LAST = 5'(NUM_ROUNDS - UNROLL);

   state_t               state, state_nx;
   logic [4:0]           round_q, round_nx;
   logic                 phase, phase_nx;       // 0 = absorbing, 1 = squeezing
   logic [CNT_WIDTH-1:0] in_rem, in_rem_nx;
   logic [CNT_WIDTH-1:0] out_rem, out_rem_nx;

   // State and counter registers; reset aborts any hash in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         round_q <= 5'd0;
         phase   <= 1'b0;
         in_rem  <= '0;
         out_rem <= '0;
      end else begin
         state   <= state_nx;
         round_q <= round_nx;
         phase   <= phase_nx;
         in_rem  <= in_rem_nx;
         out_rem <= out_rem_nx;
      end
   end

   // Next-state logic and strobes; every strobe is a function of the current state and inputs.
   always_comb begin
      state_nx   = state;
      round_nx   = round_q;
      phase_nx   = phase;
      in_rem_nx  = in_rem;
      out_rem_nx = out_rem;
      in_ready   = 1'b0;
      absorb_en  = 1'b0;
      state_clr  = 1'b0;
      round_en   = 1'b0;
      round      = 5'd0;
      out_valid  = 1'b0;
      done       = 1'b0;
      busy       = (state != IDLE);

      case (state)
         IDLE: begin
            if (start) begin
               in_rem_nx  = num_in_blocks;
               out_rem_nx = num_out_blocks;
               phase_nx   = 1'b0;
               round_nx   = 5'd0;
               state_nx   = INIT;
            end
         end
         INIT: begin
            state_clr = 1'b1;
            // An empty request in either direction has nothing to hash.
            if (in_rem == '0 || out_rem == '0) state_nx = DONE;
            else                               state_nx = ABSORB;
         end
         ABSORB: begin
            in_ready = 1'b1;
            if (in_valid) begin
               absorb_en = 1'b1;
               if (in_rem != '0) in_rem_nx = in_rem - CNT_WIDTH'(1);
               round_nx = 5'd0;
               state_nx = PERMUTE;
            end
         end
         PERMUTE: begin
            round_en = 1'b1;
            round    = round_q;
            if (round_q == LAST) begin
               round_nx = 5'd0;
               if (phase) begin
                  state_nx = SQUEEZE;
               end else if (in_rem != '0) begin
                  state_nx = ABSORB;
               end else begin
                  phase_nx = 1'b1;
                  state_nx = SQUEEZE;
               end
            end else begin
               round_nx = round_q + STEP;
            end
         end
         SQUEEZE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (out_rem != '0) out_rem_nx = out_rem - CNT_WIDTH'(1);
               // The last block leaves the counter at zero; otherwise permute for the next one.
               if (out_rem <= CNT_WIDTH'(1)) begin
                  state_nx = DONE;
               end else begin
                  round_nx = 5'd0;
                  state_nx = PERMUTE;
               end
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Bench for keccak_round_ctrl: table of whole-hash vectors plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, before the rising edge.
// A second instance with UNROLL=4 checks the strided round sequence.
module tb_keccak_round_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [15:0] num_in_blocks, num_out_blocks;
   logic        in_valid, out_ready;
   logic        in_ready, absorb_en, state_clr, round_en, out_valid, busy, done;
   logic [4:0]  round;

   logic        start4;
   logic [15:0] num_in4, num_out4;
   logic        in_valid4, out_ready4;
   logic        in_ready4, absorb_en4, state_clr4, round_en4, out_valid4, busy4, done4;
   logic [4:0]  round4;

   keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(1), .CNT_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .num_in_blocks(num_in_blocks), .num_out_blocks(num_out_blocks),
      .in_valid(in_valid), .in_ready(in_ready), .absorb_en(absorb_en),
      .state_clr(state_clr), .round_en(round_en), .round(round),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
   );

   keccak_round_ctrl #(.NUM_ROUNDS(24), .UNROLL(4), .CNT_WIDTH(16)) dut4 (
      .clk(clk), .reset(reset), .start(start4),
      .num_in_blocks(num_in4), .num_out_blocks(num_out4),
      .in_valid(in_valid4), .in_ready(in_ready4), .absorb_en(absorb_en4),
      .state_clr(state_clr4), .round_en(round_en4), .round(round4),
      .out_valid(out_valid4), .out_ready(out_ready4), .busy(busy4), .done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // sampled values and event counters
   logic        s_clr, s_inrdy, s_abs, s_ren, s_ovld, s_busy, s_done;
   logic [4:0]  s_round;
   logic [11:0] s_vec;
   int cnt_clr, cnt_abs, cnt_inrdy, cnt_ren, cnt_ohs, cnt_ovld, cnt_done, cnt_busy;
   int rnd_err = 0, abs_err = 0, cnt_done4 = 0;
   logic        p_ren = 1'b0;
   logic [4:0]  p_round = 5'd0;
   logic [4:0]  q4[$];

   typedef struct {
      logic [15:0] ni;
      logic [15:0] no;
      int clr, abs, ren, ohs, dn, bsy;
   } vec_t;
   vec_t tbl[6];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      else passed++;
   endtask

   task automatic clear_counts();
      cnt_clr = 0; cnt_abs = 0; cnt_inrdy = 0; cnt_ren = 0;
      cnt_ohs = 0; cnt_ovld = 0; cnt_done = 0; cnt_busy = 0;
   endtask

   // Capture one cycle of outputs and run the round-index reference model.
   task automatic sample();
      logic [4:0] exp_r;
      s_clr = state_clr; s_inrdy = in_ready; s_abs = absorb_en; s_ren = round_en;
      s_ovld = out_valid; s_busy = busy; s_done = done; s_round = round;
      s_vec = {state_clr, in_ready, absorb_en, round_en, out_valid, busy, done, round};
      cnt_clr   += int'(state_clr);
      cnt_abs   += int'(absorb_en);
      cnt_inrdy += int'(in_ready);
      cnt_ren   += int'(round_en);
      cnt_ohs   += int'(out_valid && out_ready);
      cnt_ovld  += int'(out_valid);
      cnt_done  += int'(done);
      cnt_busy  += int'(busy);
      if (round_en) begin
         exp_r = (p_ren && p_round != 5'd23) ? p_round + 5'd1 : 5'd0;
         if (round != exp_r) rnd_err++;
      end else if (round != 5'd0) begin
         rnd_err++;
      end
      if (absorb_en != (in_valid && in_ready)) abs_err++;
      p_ren = round_en;
      p_round = round;
      if (round_en4) q4.push_back(round4);
      cnt_done4 += int'(done4);
   endtask

   task automatic cyc();
      #1;
      sample();
      @(negedge clk);
   endtask

   task automatic run_hash(input logic [15:0] ni, input logic [15:0] no);
      clear_counts();
      num_in_blocks = ni; num_out_blocks = no;
      in_valid = 1'b1; out_ready = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         cyc();
         if (!s_busy) break;
      end
      chk("hash_terminates", int'(s_busy), 0);
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   initial begin
      int n, bad, found;
      tbl[0] = '{16'd1, 16'd1, 1, 1, 24,  1, 1, 28};
      tbl[1] = '{16'd3, 16'd2, 1, 3, 96,  2, 1, 103};
      tbl[2] = '{16'd2, 16'd1, 1, 2, 48,  1, 1, 53};
      tbl[3] = '{16'd1, 16'd3, 1, 1, 72,  3, 1, 78};
      tbl[4] = '{16'd0, 16'd5, 1, 0, 0,   0, 1, 2};
      tbl[5] = '{16'd4, 16'd0, 1, 0, 0,   0, 1, 2};

      // reset held with start and in_valid high: reset must dominate
      reset = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      num_in_blocks = 16'd1; num_out_blocks = 16'd1;
      start4 = 1'b1; in_valid4 = 1'b1; out_ready4 = 1'b1; num_in4 = 16'd1; num_out4 = 16'd1;
      clear_counts();
      repeat (2) @(negedge clk);
      cyc();
      chk("reset_outputs", int'(s_vec), 0);
      chk("reset_outputs_u4", int'({busy4, round_en4, round4}), 0);
      reset = 1'b0; start = 1'b0; start4 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      cyc();
      chk("idle_after_reset", int'(s_vec), 0);

      // table of complete hashes with in_valid/out_ready held high
      for (int i = 0; i < 6; i++) begin
         run_hash(tbl[i].ni, tbl[i].no);
         chk($sformatf("v%0d_state_clr", i), cnt_clr,   tbl[i].clr);
         chk($sformatf("v%0d_absorb", i),    cnt_abs,   tbl[i].abs);
         chk($sformatf("v%0d_in_ready", i),  cnt_inrdy, tbl[i].abs);
         chk($sformatf("v%0d_round_en", i),  cnt_ren,   tbl[i].ren);
         chk($sformatf("v%0d_out_hs", i),    cnt_ohs,   tbl[i].ohs);
         chk($sformatf("v%0d_out_valid", i), cnt_ovld,  tbl[i].ohs);
         chk($sformatf("v%0d_done", i),      cnt_done,  tbl[i].dn);
         chk($sformatf("v%0d_busy", i),      cnt_busy,  tbl[i].bsy);
      end

      // single block, delayed in_valid, output backpressure for 10 cycles
      clear_counts();
      num_in_blocks = 16'd1; num_out_blocks = 16'd1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      chk("t1_state_clr", int'(s_clr), 1);
      cyc();
      chk("t1_in_ready_latency", int'(s_inrdy), 1);
      cyc();
      cyc();
      chk("t1_no_absorb_while_invalid", cnt_abs + cnt_ren, 0);
      in_valid = 1'b1;
      cyc();
      chk("t1_absorb_en", int'(s_abs), 1);
      in_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         cyc();
         if (s_ren) n++;
         else break;
      end
      chk("t1_permute_cycles", n, 24);
      chk("t1_out_valid_after_perm", int'(s_ovld), 1);
      bad = 0;
      for (int k = 0; k < 9; k++) begin
         cyc();
         if (!s_ovld || s_ren || s_round != 5'd0 || s_done) bad++;
      end
      chk("t4_backpressure_hold", bad, 0);
      out_ready = 1'b1;
      cyc();
      chk("t4_handshake_out_valid", int'(s_ovld), 1);
      out_ready = 1'b0;
      cyc();
      chk("t1_done", int'(s_done), 1);
      chk("t1_busy_in_done", int'(s_busy), 1);
      cyc();
      chk("t1_idle_after_done", int'(s_busy), 0);
      chk("t1_done_count", cnt_done, 1);

      // reset in the middle of a permutation
      clear_counts();
      in_valid = 1'b1; out_ready = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 60; k++) begin
         cyc();
         if (s_ren && s_round == 5'd9) begin
            found = 1;
            break;
         end
      end
      chk("t5_reach_round9", found, 1);
      reset = 1'b1;
      cyc();
      chk("t5_round_at_reset", int'(s_round), 10);
      reset = 1'b0;
      cyc();
      chk("t5_outputs_after_reset", int'(s_vec), 0);
      repeat (3) cyc();
      chk("t5_no_done", cnt_done, 0);
      run_hash(16'd1, 16'd1);
      chk("t5_restart_round_en", cnt_ren, 24);
      chk("t5_restart_done", cnt_done, 1);

      // zero input blocks, second start while busy in DONE
      clear_counts();
      num_in_blocks = 16'd0; num_out_blocks = 16'd3;
      in_valid = 1'b1; out_ready = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      chk("t6_state_clr", int'(s_clr), 1);
      start = 1'b1;
      cyc();
      chk("t6_done", int'(s_done), 1);
      start = 1'b0;
      repeat (4) cyc();
      chk("t6_done_count", cnt_done, 1);
      chk("t6_no_handshakes", cnt_inrdy + cnt_ren + cnt_ovld, 0);
      chk("t6_idle", int'(s_busy), 0);

      // start pulse during PERMUTE is ignored
      clear_counts();
      num_in_blocks = 16'd1; num_out_blocks = 16'd1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (s_ren) break;
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         cyc();
         if (!s_busy) break;
      end
      repeat (3) cyc();
      chk("t6_busy_start_done", cnt_done, 1);
      chk("t6_busy_start_round_en", cnt_ren, 24);
      in_valid = 1'b0; out_ready = 1'b0;

      // UNROLL=4 instance: rounds 0,4,...,20
      q4.delete();
      cnt_done4 = 0;
      start4 = 1'b1;
      cyc();
      start4 = 1'b0;
      repeat (40) cyc();
      chk("t3_round_en_cycles", q4.size(), 6);
      for (int i = 0; i < 6 && i < q4.size(); i++)
         chk($sformatf("t3_round_%0d", i), int'(q4[i]), 4 * i);
      chk("t3_done", cnt_done4, 1);

      chk("round_model_errors", rnd_err, 0);
      chk("absorb_rule_errors", abs_err, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/keccak_round_ctrl.md
Name: keccak_round_ctrl

Overview:
Sequencing controller for the iterative Keccak-f[1600] permutation core in the BIKE hash path (SHAKE-style absorb/permute/squeeze). It drives the 5-bit round index into the round-constant lookup and the round-enable of the permutation datapath. It also handshakes message blocks in and digest blocks out. The controller holds no state data; it issues only control strobes.

Parameters:
NUM_ROUNDS, 24, permutation rounds per Keccak-f call; the index range is 0..NUM_ROUNDS-1, and 24 is the only supported value.
UNROLL, 1, rounds computed per clock by the datapath; legal values 1, 2, 3, 4, 6, 8, 12, 24.
CNT_WIDTH, 16, width of the block counters.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a hash; sampled only in IDLE
num_in_blocks  in  CNT_WIDTH  number of rate blocks to absorb; latched on accepted start
num_out_blocks  in  CNT_WIDTH  number of rate blocks to squeeze; latched on accepted start
in_valid  in  1  input block available at the datapath
in_ready  out  1  controller ready to absorb a block
absorb_en  out  1  XOR the input block into the state (equals in_valid & in_ready)
state_clr  out  1  zero the 1600-bit state
round_en  out  1  datapath performs UNROLL rounds this cycle
round  out  5  base round index for the constant lookup; the datapath uses round+k for k < UNROLL
out_valid  out  1  state rate portion is a valid output block
out_ready  in  1  consumer accepts the output block
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at completion

Behaviour:
- Reset: synchronous and active-high; clk and reset are as stated.
  - On the next edge: state is IDLE; all outputs are 0; round is 0; counters are 0; phase is 0.
  - Reset dominates start and all other inputs.
  - Reset mid-operation aborts without a done pulse.
- States: IDLE, INIT, ABSORB, PERMUTE, SQUEEZE, DONE.
- IDLE:
  - On start=1, latch both counts and go to INIT.
  - Start in any other state is ignored.
- INIT:
  - state_clr=1 for exactly one cycle.
  - If either latched count is 0, go to DONE (no handshakes, no permutation).
  - Otherwise go to ABSORB.
- ABSORB:
  - in_ready=1.
  - On in_valid=1: absorb_en=1 in the same cycle, in_remaining decrements, round is cleared to 0, and the next state is PERMUTE.
  - Otherwise hold with all other strobes at 0.
- PERMUTE:
  - round_en=1 every cycle.
  - round advances by UNROLL per cycle: 0, UNROLL, ..., NUM_ROUNDS-UNROLL.
  - Duration is exactly NUM_ROUNDS/UNROLL cycles, with no stalls.
  - On the cycle with round = NUM_ROUNDS-UNROLL:
    - if phase=0 and in_remaining>0, next state is ABSORB;
    - if phase=0 and in_remaining=0, set phase=1 and go to SQUEEZE;
    - if phase=1, go to SQUEEZE.
- SQUEEZE:
  - out_valid=1, held until out_ready=1. No other strobe is active while waiting.
  - On out_valid & out_ready, out_remaining decrements. If it reaches 0, go to DONE; otherwise go to PERMUTE with round=0.
- DONE: done=1 for one cycle, busy=1 in that cycle, then IDLE.
- round output:
  - Outside PERMUTE, round=0.
  - Never exceeds NUM_ROUNDS-UNROLL, so the lookup default entry is never selected.
- Block counts:
  - Counters are unsigned CNT_WIDTH.
  - No wrap: a counter decrements only when it is nonzero.
- Total round_en cycles per hash: (num_in_blocks + num_out_blocks - 1) * NUM_ROUNDS/UNROLL, for nonzero counts.
- Simultaneous events:
  - in_valid with reset: reset wins, no absorb_en.
  - out_ready with out_valid=0: ignored.
  - in_valid outside ABSORB: ignored.
- Latency, start to first in_ready: 2 cycles (IDLE→INIT→ABSORB).

Test Plan:
1. UNROLL=1, start with in=1, out=1; in_valid asserted 3 cycles after in_ready rises -> state_clr 1 cycle; absorb_en 1 cycle; round_en for exactly 24 cycles with round 0..23 consecutively; out_valid rises next cycle; out_ready=1 -> done 1 cycle later; busy falls with return to IDLE.
2. in=3, out=2, in_valid and out_ready always high -> 3 absorb_en pulses; 2 out_valid handshakes; 96 round_en cycles total (4 permutations); a single done pulse.
3. UNROLL=4, in=1, out=1 -> round sequence 0,4,8,12,16,20; 6 round_en cycles; round never reaches 24.
4. Backpressure: out_ready low for 10 cycles during SQUEEZE -> out_valid held high for all 10; round_en=0; round=0; the handshake completes on the first out_ready=1.
5. Reset asserted for 1 cycle while round=10 in PERMUTE -> next cycle IDLE, all outputs 0, no done; a following start with in=1, out=1 completes normally in 24 permute cycles.
6. Start with num_in_blocks=0 -> state_clr, then done; zero in_ready/round_en/out_valid cycles. A second start pulse while busy=1 is ignored (still exactly one done).
